// File: rtl/pmod_adc_reader_if.sv
// Serial bus between the PMOD ADC reader and an AD7476A-class converter.
// The reader drives chip select and the serial clock. The ADC returns serial data.
interface pmod_adc_reader_if;
    logic cs_n;
    logic sclk;
    logic sdata;

    modport master (output cs_n, output sclk, input sdata);
    modport slave  (input cs_n, input sclk, output sdata);
endinterface

// File: rtl/pmod_adc_reader.sv
// Free-running SPI reader for a 12-bit PMOD ADC. It returns both the raw offset-binary
// code and a mid-scale-centred two's complement sample for the scope/waveform path.
module pmod_adc_reader #(
    parameter int width         = 12,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 256
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               enable,
    pmod_adc_reader_if.master  adc,
    output logic [width-1:0]   sample,
    output logic [width-1:0]   sample_signed,
    output logic               sample_valid,
    output logic               frame_err,
    output logic               busy
);

    localparam int FRAME_BITS = width + 4;
    localparam int PW         = $clog2(SAMPLE_PERIOD);
    localparam int CW         = $clog2(2 * CLK_DIV);
    localparam int RW         = $clog2(FRAME_BITS + 1);

    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] QUIET_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [RW-1:0] LAST_RISE   = RW'(FRAME_BITS - 1);

    if (CLK_DIV < 3) begin : g_bad_clk_div
        $error("pmod_adc_reader: CLK_DIV must be >= 3");
    end
    if (SAMPLE_PERIOD < (2 * FRAME_BITS + 1) * CLK_DIV + 2 * CLK_DIV) begin : g_bad_period
        $error("pmod_adc_reader: SAMPLE_PERIOD too small for one frame plus quiet time");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_TAIL,
        S_QUIET
    } state_t;

    state_t                  state;
    logic [PW-1:0]           period_cnt;
    logic [CW-1:0]           phase_cnt;
    logic [RW-1:0]           rise_cnt;
    logic [FRAME_BITS-1:0]   shreg;
    logic [1:0]              sdata_sync;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sdata_sync <= '0;
        end else begin
            sdata_sync <= {sdata_sync[0], adc.sdata};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            period_cnt   <= '0;
            phase_cnt    <= '0;
            rise_cnt     <= '0;
            shreg        <= '0;
            adc.cs_n     <= 1'b1;
            adc.sclk     <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low with non-blocking assignments; the branches below only raise them.
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            period_cnt   <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (period_cnt == PERIOD_LAST && enable) begin
                        state     <= S_FRAME;
                        adc.cs_n  <= 1'b0;
                        busy      <= 1'b1;
                        phase_cnt <= '0;
                        rise_cnt  <= '0;
                    end
                end

                S_FRAME: begin
                    if (phase_cnt == DIV_LAST) begin
                        phase_cnt <= '0;
                        adc.sclk  <= ~adc.sclk;
                        // The ADC updates data on the falling edge, so capture on the rising edge.
                        if (!adc.sclk) begin
                            shreg    <= {shreg[FRAME_BITS-2:0], sdata_sync[1]};
                            rise_cnt <= rise_cnt + 1'b1;
                            if (rise_cnt == LAST_RISE) begin
                                state <= S_TAIL;
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_TAIL: begin
                    if (phase_cnt == DIV_LAST) begin
                        phase_cnt <= '0;
                        adc.cs_n  <= 1'b1;
                        state     <= S_QUIET;
                        if (shreg[FRAME_BITS-1 -: 4] == 4'd0) begin
                            sample       <= shreg[width-1:0];
                            sample_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                S_QUIET: begin
                    if (phase_cnt == QUIET_LAST) begin
                        phase_cnt <= '0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Flipping the MSB of an offset-binary code gives two's complement about mid-scale.
    assign sample_signed = {~sample[width-1], sample[width-2:0]};

endmodule

// File: tb/tb_pmod_adc_reader.sv
// Randomised scoreboard bench for pmod_adc_reader: an ADC model serves 16-bit frames,
// and a monitor checks frame timing and every result against a behavioural model.
module tb_pmod_adc_reader;

    localparam int PERIOD   = 256;
    localparam int LATENCY  = 132;
    localparam int BUSY_LEN = 140;

    logic        clock;
    logic        resetn;
    logic        enable;
    logic [11:0] sample;
    logic [11:0] sample_signed;
    logic        sample_valid;
    logic        frame_err;
    logic        busy;

    pmod_adc_reader_if adc_if ();

    pmod_adc_reader #(
        .width         (12),
        .CLK_DIV       (4),
        .SAMPLE_PERIOD (PERIOD)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .enable        (enable),
        .adc           (adc_if),
        .sample        (sample),
        .sample_signed (sample_signed),
        .sample_valid  (sample_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] adc_words[$];
    logic [15:0] sb_q[$];
    int          model_last = 0;

    int cyc = 0;
    int last_fall = 0;
    int fall_count = 0;
    int rises = 0;
    int valid_count = 0;
    int err_count = 0;
    bit have_fall = 0;
    bit in_frame = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    task automatic check(input string name, input integer actual, input integer expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [15:0] rand_word();
        logic [3:0] lead;
        lead = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        return {lead, 12'($urandom_range(0, 4095))};
    endfunction

    // ADC model: bit 15 appears after the first SCLK fall, bit 0 after the sixteenth.
    initial begin
        logic [15:0] w;
        adc_if.sdata = 1'b0;
        forever begin
            @(negedge adc_if.cs_n);
            if (adc_words.size() == 0) adc_words.push_back(rand_word());
            w = adc_words.pop_front();
            sb_q.push_back(w);
            for (int k = 1; k <= 16; k++) begin
                @(negedge adc_if.sclk or posedge adc_if.cs_n);
                if (adc_if.cs_n) break;
                adc_if.sdata = w[16-k];
            end
        end
    end

    // Monitor: frame timing checks and scoreboard comparison of every result pulse.
    initial begin
        logic        prev_cs = 1'b1;
        logic        prev_sclk = 1'b1;
        logic        prev_busy = 1'b0;
        logic [15:0] w;
        int          exp_signed;
        forever begin
            @(negedge clock);
            cyc++;
            if (!resetn) begin
                have_fall = 0;
                in_frame  = 0;
            end else begin
                if (prev_cs && !adc_if.cs_n) begin
                    if (have_fall) check("cs_fall_spacing", (cyc - last_fall) % PERIOD, 0);
                    last_fall = cyc;
                    have_fall = 1;
                    in_frame  = 1;
                    rises     = 0;
                    fall_count++;
                end
                if (in_frame && !prev_sclk && adc_if.sclk) rises++;
                if (in_frame && !prev_cs && adc_if.cs_n) begin
                    check("cs_low_cycles", cyc - last_fall, LATENCY);
                    check("sclk_rises", rises, 16);
                    in_frame = 0;
                end
                if (have_fall && prev_busy && !busy) check("busy_fall_delay", cyc - last_fall, BUSY_LEN);
                if (sample_valid || frame_err) begin
                    valid_count += int'(sample_valid);
                    err_count   += int'(frame_err);
                    check("valid_err_exclusive", sample_valid & frame_err, 0);
                    check("result_latency", cyc - last_fall, LATENCY);
                    check("result_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        w = sb_q.pop_front();
                        if (w[15:12] == 4'd0) model_last = int'(w[11:0]);
                        check("result_kind_valid", sample_valid, w[15:12] == 4'd0);
                        check("sample", sample, model_last);
                        exp_signed = (model_last >= 2048) ? model_last - 2048 : model_last + 2048;
                        check("sample_signed", sample_signed, exp_signed);
                    end
                end
            end
            prev_cs   = adc_if.cs_n;
            prev_sclk = adc_if.sclk;
            prev_busy = busy;
        end
    end

    task automatic wait_rise(input int n, input string name);
        for (int i = 0; i < 1000 && !(in_frame && rises >= n); i++) tick();
        check(name, in_frame && rises >= n, 1);
    endtask

    initial begin
        int f0;
        int r0;
        int expect_fall;

        resetn = 1'b0;
        enable = 1'b0;
        adc_words.push_back(16'h0A5C);
        adc_words.push_back(16'h0800);
        adc_words.push_back(16'h0000);
        adc_words.push_back(16'h0FFF);
        adc_words.push_back(16'h4123);
        repeat (3) tick();

        check("reset_cs_n", adc_if.cs_n, 1);
        check("reset_sclk", adc_if.sclk, 1);
        check("reset_sample", sample, 12'h000);
        check("reset_sample_signed", sample_signed, 12'h800);
        check("reset_sample_valid", sample_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);

        // Directed words (basic, signed mapping, frame error) followed by random frames.
        resetn = 1'b1;
        enable = 1'b1;
        repeat (9 * PERIOD) tick();
        check("directed_results", valid_count + err_count >= 5, 1);

        // Periodicity with enable held high.
        f0 = fall_count;
        repeat (4 * PERIOD) tick();
        check("periodicity_falls", fall_count - f0, 4);

        // Enable dropped mid-frame: the frame completes, and nothing new starts.
        wait_rise(8, "wait_rise8");
        enable = 1'b0;
        f0 = fall_count;
        r0 = valid_count + err_count;
        repeat (700) tick();
        check("enable_drop_completes", valid_count + err_count - r0, 1);
        check("enable_drop_no_restart", fall_count - f0, 0);

        // Re-raising enable mid-period starts only at the next boundary.
        for (int i = 0; i < PERIOD && ((cyc - last_fall) % PERIOD) != 100; i++) tick();
        enable = 1'b1;
        expect_fall = last_fall + ((cyc - last_fall) / PERIOD + 1) * PERIOD;
        f0 = fall_count;
        for (int i = 0; i < 600 && fall_count == f0; i++) tick();
        check("restart_seen", fall_count - f0, 1);
        check("restart_at_boundary", last_fall, expect_fall);

        // Asynchronous reset mid-frame, applied between clock edges.
        wait_rise(5, "wait_rise5");
        #1;
        resetn = 1'b0;
        #1;
        check("async_reset_cs_n", adc_if.cs_n, 1);
        check("async_reset_sclk", adc_if.sclk, 1);
        check("async_reset_sample", sample, 12'h000);
        check("async_reset_valid", sample_valid, 0);
        sb_q.delete();
        model_last = 0;
        adc_words.delete();
        adc_words.push_back(16'h0321);
        repeat (3) tick();
        resetn = 1'b1;
        r0 = valid_count;
        for (int i = 0; i < 700 && valid_count == r0; i++) tick();
        check("post_reset_valid", valid_count - r0, 1);
        check("post_reset_sample", sample, 12'h321);

        enable = 1'b0;
        repeat (400) tick();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pmod_adc_reader.md
Name: pmod_adc_reader

Overview:
- SPI reader for a 12-bit PMOD ADC (AD7476A-class): 16-SCLK frames with 4 leading zeros, then 12 data bits MSB first.
- Provides the return path for the waveform generator. The analogue output of the PWM/DAC is digitised back into a signed 12-bit sample.
- Its output is in the same signed format the VGA scope and waveform mux consume, so the reconstructed waveform can be displayed or compared against the generated one.
- Free-running: starts one conversion every SAMPLE_PERIOD clocks while enabled.

Parameters:
- width, 12: data bits per conversion. Frame length is fixed at width+4 SCLK periods.
- CLK_DIV, 4: clock cycles per SCLK half-period. Must be >= 3.
- SAMPLE_PERIOD, 256: clock cycles between conversion starts. Must be >= (2*(width+4)+1)*CLK_DIV + 2*CLK_DIV.

Ports:
- clock, input, 1: system clock.
- resetn, input, 1: asynchronous active-low reset. All flops clear immediately on assertion; release is synchronous to clock.
- enable, input, 1: allows new conversions to start. It is sampled only at a period boundary.
- sdata, input, 1: serial data from the ADC. It is asynchronous and passes through a 2-flop synchroniser internally.
- cs_n, output, 1: ADC chip select, active low.
- sclk, output, 1: ADC serial clock, idle high.
- sample, output, width: last good conversion, raw offset-binary.
- sample_signed, output, width: sample with its MSB inverted, i.e. two's complement centred at mid-scale.
- sample_valid, output, 1: one-cycle pulse when sample and sample_signed update.
- frame_err, output, 1: one-cycle pulse when a frame is rejected.
- busy, output, 1: high from the cycle cs_n falls through the end of QUIET.

Behaviour:
Reset values:
- cs_n=1, sclk=1.
- sample=0, sample_signed=0x800 for width=12 (MSB set).
- sample_valid=0, frame_err=0, busy=0.
- Period counter=0, state=IDLE, shift register=0.

Period counter:
- Counts 0..SAMPLE_PERIOD-1 and wraps; runs regardless of enable.
- When the counter equals SAMPLE_PERIOD-1, state is IDLE and enable=1, the next cycle (T0) enters FRAME.
- At T0, cs_n=0 and busy=1.

FSM: IDLE -> FRAME -> TAIL -> QUIET -> IDLE.
- FRAME:
  - The divider toggles sclk every CLK_DIV cycles.
  - The first fall is at T0+CLK_DIV; rise k (k=1..16) is at T0+2k*CLK_DIV.
  - On the clock edge that drives sclk 0->1, the shift register shifts left and takes the synchronised sdata.
  - After the 16th rise, go to TAIL. sclk stays high.
- TAIL:
  - Lasts CLK_DIV cycles.
  - At T0+33*CLK_DIV: cs_n=1, and the frame is checked.
  - If the top 4 shifted bits are all 0: sample and sample_signed load and sample_valid=1 for exactly that cycle.
  - Otherwise: sample is unchanged and frame_err=1 for that cycle.
  - Go to QUIET.
- QUIET:
  - Lasts 2*CLK_DIV cycles with cs_n=1 and sclk=1.
  - busy drops on the cycle QUIET exits.
  - Return to IDLE.

Latency: start to sample_valid is 33*CLK_DIV cycles (132 at defaults).

Boundary conditions:
- enable deasserted mid-frame: the frame completes normally, including the result pulse. No further starts until enable=1 at a boundary.
- enable toggled between boundaries: no effect.
- Period boundary while not IDLE: that start is skipped. Unreachable with legal parameters.
- resetn asserted mid-frame: cs_n and sclk return high immediately and no sample_valid is produced. After release, the next start occurs at the first boundary with enable=1.
- sample_valid and frame_err are never high in the same cycle.
- Illegal parameters (CLK_DIV<3 or SAMPLE_PERIOD too small) trigger a simulation-time $error.

Test Plan:
1. Basic conversion. ADC model returns 0000_1010_0101_1100 (0xA5C), updating sdata on each sclk fall; defaults; enable=1.
   - Required: cs_n low for exactly 132 cycles and exactly 16 sclk rises.
   - Required: sample=0xA5C, sample_signed=0x25C, sample_valid high 1 cycle at T0+132.
2. Signed mapping. Codes 0x800, 0x000, 0xFFF.
   - Required: sample_signed = 0x000, 0x800, 0x7FF respectively.
3. Frame error. Leading nibble 0100, data 0x123.
   - Required: frame_err pulses once; sample keeps its previous value; sample_valid stays 0.
4. Periodicity. enable=1 for 4 periods.
   - Required: cs_n falls exactly 256 cycles apart; busy deasserts 140 cycles after each fall.
5. Enable control. Drop enable at sclk rise 8.
   - Required: the frame completes with a valid sample and no further cs_n activity.
   - Required: re-raising enable mid-period gives a start only at the next boundary.
6. Reset mid-frame. Assert resetn=0 at sclk rise 5, asynchronously between clock edges.
   - Required: cs_n=1, sclk=1 and sample=0 without waiting for a clock edge; no sample_valid.
   - Required: after release, the first conversion yields the correct model value.
